mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
Multi-cycle multiply/divide sequencer for the EX stage. It iterates one 33-bit add/subtract path for 32 cycles to execute MULT, MULTU, DIV and DIVU, and holds the results in architectural HI/LO registers. It drives `busy` so the hazard unit can stall later MFHI/MFLO/MULT/DIV instructions, and it accepts MTHI/MTLO writes when idle.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported.
CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  32  rs operand (multiplicand/dividend)
b  input  32  rt operand (multiplier/divisor)
flush  input  1  synchronous abort (exception/branch squash)
hi_we  input  1  MTHI write
lo_we  input  1  MTLO write
wdata  input  32  MTHI/MTLO data
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when HI/LO are updated by an op
dz  output  1  sticky divide-by-zero flag of last divide, cleared on next start
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, resetn=0): state=IDLE, hi=lo=0, busy=0, done=0, dz=0, counter=0, internal regs=0. Reset mid-operation abandons the op with no result.
- States: IDLE, PREP, RUN, FIX.
- IDLE: priority is flush > start > hi_we/lo_we.
  - flush: nothing happens.
  - start: latch op, a, b → PREP.
  - Otherwise hi_we/lo_we write wdata into hi/lo. Writes while busy are ignored.
- PREP (1 cycle):
  - Signed ops take magnitudes of a and b. Record result sign (a[31]^b[31]) and remainder sign (a[31]).
  - Clear the accumulator. counter=0. dz = (op is divide && b==0).
- RUN (exactly 32 cycles; counter 0..31; exits to FIX when counter==31):
  - Multiply: shift-add, one 33-bit add per cycle.
  - Divide: restoring division; 33-bit trial subtract, quotient bit = no-borrow.
- FIX (1 cycle):
  - Negate the product (64-bit), quotient and remainder per the recorded signs.
  - At the FIX→IDLE edge: hi/lo written, done=1 for the following cycle only.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder; the remainder takes the sign of the dividend.
- Latency: start high at edge E0 → done visible after edge E0+34; busy high after E0 through edge E0+34. Back-to-back: a start is accepted in the cycle done is high.
- Divide by zero: full latency is still spent. Result is lo=32'hFFFFFFFF, hi=a (unmodified input), dz=1.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag.
- flush while busy: next state IDLE, hi/lo unchanged, done not pulsed, dz unchanged.
- start while busy is ignored; the hazard unit guarantees a stall instead.
- Width rules: all internal sums are 33 bits; the multiply accumulator is 64 bits; the counter wraps are not used (exit at 31).

Test Plan:
- MULTU a=7, b=6 → done after 34 edges, hi=0, lo=42; busy high for exactly 34 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; then MULTU 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 → lo=14, hi=2. DIV 0xFFFFFFF9 (-7)/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → dz=1, lo=0xFFFFFFFF, hi=0x1234 at done. A following MULTU start clears dz.
- Start MULTU 3*3, assert flush at cycle 10 → busy drops next cycle, no done pulse, hi/lo keep their prior values. Assert resetn=0 mid-RUN → all outputs 0 immediately.
- IDLE with hi_we=1, wdata=0xA5A5A5A5 → hi updated. hi_we together with start → start wins, hi not written. hi_we while busy → ignored.

Source files
------------

// File: rtl/mdu_seq_if.sv
// Handshake/bus bundle between the EX stage and the multiply/divide sequencer.
interface mdu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO registers.
// One shared 33-bit adder per cycle: shift-add multiply or restoring divide.
module mdu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic       clk,
  input logic       resetn,
  mdu_seq_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPrep = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dz;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_div;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_add_a;
  logic [WIDTH:0]     w_add_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_run;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_div   = r_op[1];
  assign w_a_mag = (r_op[0] && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_b_mag = (r_op[0] && r_b[WIDTH-1]) ? -r_b : r_b;

  // Divide: {rem, next dividend bit} minus divisor; sum[WIDTH] set means borrow.
  // Multiply: upper accumulator plus multiplicand when the multiplier LSB is set.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    if (w_div) begin
      w_add_a = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_add_b = ~{1'b0, r_m};
    end else begin
      w_add_a = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
      w_add_b = r_acc[0] ? {1'b0, r_m} : '0;
    end
    w_sum = w_add_a + w_add_b + {{WIDTH{1'b0}}, w_div};
  end

  always_comb begin
    w_acc_run = '0;
    if (w_div) begin
      w_acc_run = {(w_sum[WIDTH] ? w_add_a[WIDTH-1:0] : w_sum[WIDTH-1:0]),
                   r_acc[WIDTH-2:0], ~w_sum[WIDTH]};
    end else begin
      w_acc_run = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_prod   = r_neg_res ? -r_acc : r_acc;
    w_quo    = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem    = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (w_div) begin
      // Divide by zero reports all-ones quotient and the untouched dividend.
      w_res_hi = r_dz ? r_a : w_rem;
      w_res_lo = r_dz ? '1 : w_quo;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (bus.start) w_state_nxt = StPrep;
        StPrep:  w_state_nxt = StRun;
        StRun:   if (&r_cnt) w_state_nxt = StFix;
        StFix:   w_state_nxt = StIdle;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (!bus.flush) begin
        case (r_state)
          StIdle: begin
            if (bus.start) begin
              r_op <= bus.op;
              r_a  <= bus.a;
              r_b  <= bus.b;
              r_dz <= 1'b0;
            end else begin
              if (bus.hi_we) r_hi <= bus.wdata;
              if (bus.lo_we) r_lo <= bus.wdata;
            end
          end
          StPrep: begin
            r_acc     <= {{WIDTH{1'b0}}, (w_div ? w_a_mag : w_b_mag)};
            r_m       <= w_div ? w_b_mag : w_a_mag;
            r_neg_res <= r_op[0] & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
            r_neg_rem <= r_op[0] & r_a[WIDTH-1];
            r_cnt     <= '0;
            r_dz      <= w_div && (r_b == '0);
          end
          StRun: begin
            r_acc <= w_acc_run;
            r_cnt <= r_cnt + 1'b1;
          end
          StFix: begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy = (r_state != StIdle);
  assign bus.done = r_done;
  assign bus.dz   = r_dz;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: launches push expected HI/LO/dz, a negedge monitor
// pops and compares on every done pulse.
module tb_mdu_seq;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mdu_seq_if bus_if ();

  mdu_seq u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   cyc      = 0;
  int   cyc0     = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus_if.busy === 1'b1) busy_cnt <= busy_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && bus_if.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, bus_if.hi, e.hi);
        check({e.name, "_lo"}, bus_if.lo, e.lo);
        check({e.name, "_dz"}, {31'b0, bus_if.dz}, {31'b0, e.dz});
      end
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input string name, input bit push);
    exp_t e;
    int t = 0;
    while (bus_if.busy === 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      $display("FAIL %s_idle_wait: got busy=1 after %0d cycles, expected idle", name, t);
    end
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.a     = a;
    bus_if.b     = b;
    if (push) begin
      e.hi = eh; e.lo = el; e.dz = edz; e.name = name;
      sb.push_back(e);
    end
    busy_cnt = 0;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    cyc0 = cyc;
    check({name, "_busy_at_start"}, {31'b0, bus_if.busy}, 32'd1);
    check({name, "_dz_cleared"}, {31'b0, bus_if.dz}, 32'd0);
  endtask

  task automatic wait_done(input string name, input bit timing);
    int k = 0;
    while (bus_if.done !== 1'b1 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (bus_if.done !== 1'b1) begin
      n_checks++;
      $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, k);
    end else if (timing) begin
      check({name, "_latency"}, cyc - cyc0, 32'd34);
      check({name, "_busy_cycles"}, busy_cnt, 32'd34);
      check({name, "_busy_low_at_done"}, {31'b0, bus_if.busy}, 32'd0);
    end
  endtask

  initial begin
    int nd;
    bus_if.start = 1'b0; bus_if.op = 2'b00; bus_if.a = '0; bus_if.b = '0;
    bus_if.flush = 1'b0; bus_if.hi_we = 1'b0; bus_if.lo_we = 1'b0; bus_if.wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus_if.busy}, 32'd0);
    check("rst_done", {31'b0, bus_if.done}, 32'd0);
    check("rst_dz", {31'b0, bus_if.dz}, 32'd0);
    check("rst_hi", bus_if.hi, 32'd0);
    check("rst_lo", bus_if.lo, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    launch(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, "multu_7x6", 1'b1);
    wait_done("multu_7x6", 1'b1);
    // back-to-back: start accepted while done is high
    launch(2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult_m3x5", 1'b1);
    wait_done("mult_m3x5", 1'b1);
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0,
           "multu_max", 1'b1);
    wait_done("multu_max", 1'b0);
    launch(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7", 1'b1);
    wait_done("divu_100_7", 1'b1);
    launch(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2", 1'b1);
    wait_done("div_m7_2", 1'b0);
    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_ovf", 1'b1);
    wait_done("div_ovf", 1'b0);
    launch(2'b10, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, "divu_dz", 1'b1);
    wait_done("divu_dz", 1'b1);

    // Flush mid-run: no done, HI/LO hold the divide-by-zero result.
    launch(2'b00, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, "multu_flush", 1'b0);
    nd = n_done;
    repeat (9) @(posedge clk);
    #1;
    bus_if.flush = 1'b1;
    @(posedge clk);
    #1;
    bus_if.flush = 1'b0;
    check("flush_busy", {31'b0, bus_if.busy}, 32'd0);
    check("flush_hi", bus_if.hi, 32'h0000_1234);
    check("flush_lo", bus_if.lo, 32'hFFFF_FFFF);
    check("flush_dz", {31'b0, bus_if.dz}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_done", n_done - nd, 32'd0);

    bus_if.hi_we = 1'b1;
    bus_if.wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    bus_if.hi_we = 1'b0;
    check("mthi_hi", bus_if.hi, 32'hA5A5_A5A5);
    check("mthi_lo_kept", bus_if.lo, 32'hFFFF_FFFF);
    bus_if.lo_we = 1'b1;
    bus_if.wdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    bus_if.lo_we = 1'b0;
    check("mtlo_lo", bus_if.lo, 32'h5A5A_5A5A);
    check("mtlo_hi_kept", bus_if.hi, 32'hA5A5_A5A5);

    // hi_we alongside start, then held while busy: both ignored.
    bus_if.hi_we = 1'b1;
    bus_if.wdata = 32'h1111_1111;
    launch(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "multu_2x3", 1'b1);
    check("start_beats_mthi", bus_if.hi, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    bus_if.hi_we = 1'b0;
    check("mthi_busy_ignored", bus_if.hi, 32'hA5A5_A5A5);
    wait_done("multu_2x3", 1'b0);

    // Async reset mid-run abandons the op.
    launch(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, "multu_rst", 1'b0);
    repeat (15) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_busy", {31'b0, bus_if.busy}, 32'd0);
    check("midrst_done", {31'b0, bus_if.done}, 32'd0);
    check("midrst_dz", {31'b0, bus_if.dz}, 32'd0);
    check("midrst_hi", bus_if.hi, 32'd0);
    check("midrst_lo", bus_if.lo, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    launch(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "mult_min_m1", 1'b1);
    wait_done("mult_min_m1", 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("done_count", n_done, 32'd9);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
